io_port_ctrl: RTL and testbench
===============================

# io_port_ctrl

Parametrised memory-mapped GPIO controller for the Ahmes CPU data bus. It is the successor to the 4-in/4-out I/O block and has configurable input and output widths. Features: double-flop input synchronisation, optional per-bit debounce, LED set/toggle writes with readback, and programmable-polarity edge detection with a write-1-to-clear status register and an interrupt line. It sits on the CPU data bus alongside memory, decoded by the top-level address mux.

## Interface
- IN_W, default 4: number of switch inputs, 1..8.
- OUT_W, default 4: number of LED outputs, 1..8.
- DEB_CYCLES, default 4: consecutive stable cycles required before a debounced input changes, ≥1. Ignored when debounce is compiled out.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- addr  in  8  register address.
- write_data  in  8  write data; only the low OUT_W or IN_W bits are used, per register.
- write_en  in  1  write strobe; one write per cycle at the rising edge.
- read_en  in  1  read strobe.
- read_data  out  8  combinational read data, zero-extended; 0x00 when read_en=0 or the address is unmapped.
- in_switches  in  IN_W  asynchronous raw inputs.
- out_leds  out  OUT_W  LED register.
- irq  out  1  |(edge_status & edge_mask).

## Operation
Register map:
- 0x00 LED, RW. Write loads led[OUT_W-1:0]. Read returns the LED value.
- 0x01 LED_TOGGLE, WO. Write does led ^= write_data. Read returns 0x00.
- 0x04 SWITCH, RO. Returns the debounced switch value.
- 0x05 EDGE_STATUS, RW1C. Each written 1 clears the matching bit. Read returns the status.
- 0x06 EDGE_MASK, RW. Selects which status bits drive irq.
- 0x07 EDGE_POL, RW. Bit=1 detects rising edges; bit=0 detects falling edges.
- All other addresses: reads return 0x00 and writes are ignored.

Input path:
- in_switches passes through a 2-flop synchronizer to give sync.
- With debounce enabled, sync then passes through the per-bit debouncer to give stable.
- stable_d is stable delayed by one cycle.
- A bit's edge event is (stable & ~stable_d) when its pol bit is 1, and (~stable & stable_d) when its pol bit is 0.

Status update:
- An edge event sets its status bit.
- When a set and a W1C hit the same bit in the same cycle, the set wins.
- Changing EDGE_POL does not itself generate an event.

Reset values:
- led, status, mask, sync stages, stable, stable_d and debounce counters are all 0.
- pol is all ones (rising).
- out_leds is 0 and irq is 0.
- Reset mid-debounce discards any partial count.

## Timing
Input path, numbering from the first clk edge after in_switches changes (edge 1):
- sync is valid after edge 2.
- Without debounce, stable = sync, so SWITCH reads the new value after edge 2 and the status bit and irq rise after edge 3.
- With debounce, stable changes at edge 2+DEB_CYCLES and the status bit and irq rise after edge 3+DEB_CYCLES.

Debouncer, per bit, with a counter of width $clog2(DEB_CYCLES):
- If sync == stable, the counter clears.
- Otherwise, if the counter == DEB_CYCLES-1, stable takes sync and the counter clears.
- Otherwise the counter increments.
- A glitch shorter than DEB_CYCLES cycles never reaches stable.

Writes and reads:
- Writes take effect at the clk edge where write_en=1. out_leds changes after that edge.
- After a W1C write, irq falls combinationally in the next cycle.
- read_data is combinational in the same cycle, so a read in the cycle of a write returns the pre-write value.
- If read_en and write_en are both high, both are serviced.

## Configuration
- IO_DEBOUNCE_EN defined: the debouncer is instantiated per bit as described above.
- IO_DEBOUNCE_EN undefined: stable = sync directly, no counters are synthesised, and DEB_CYCLES is unused. Register map and edge logic are unchanged.

## Structure
- Package io_pkg holds the address localparams (IO_ADDR_LED, IO_ADDR_LED_TOGGLE, IO_ADDR_SWITCH, IO_ADDR_EDGE_STATUS, IO_ADDR_EDGE_MASK, IO_ADDR_EDGE_POL) and the maximum width constant IO_MAX_W = 8.
- One sub-module, io_debounce: a single-bit debouncer parametrised by DEB_CYCLES. It is instantiated IN_W times in a generate loop under IO_DEBOUNCE_EN.

## Test plan
- LED write and toggle: with OUT_W=4, write 0x00←0x0A, then 0x01←0x0F. Required: out_leds = 0x5 and a read of 0x00 returns 0x05. Also write 0x00←0xFF and read back 0x0F, confirming upper bits are dropped.
- Synchronizer and SWITCH read, debounce off: in_switches goes 0x0→0x9. Required: a read of 0x04 returns 0x09 exactly after edge 2, and 0x00 before it.
- Debounce, DEB_CYCLES=4:
  - A 3-cycle pulse on bit 0 produces no SWITCH change and no status.
  - A held level makes SWITCH change after edge 6 and status bit 0 set after edge 7.
- Edges, mask and irq:
  - mask=0x1 and pol=0x1: a rising edge on bit 0 makes irq=1.
  - W1C with 0x01 makes irq=0 the next cycle.
  - pol=0x0: a falling edge sets status and a rising edge does not.
  - An unmasked bit sets status but leaves irq at 0.
- Collision: a W1C of bit 2 issued in the same cycle as a new bit-2 event leaves status bit 2 = 1.
- Reset: assert reset_n low mid-debounce with led=0xF. Required: out_leds, irq and read_data are 0 immediately. After release, the held input needs a full DEB_CYCLES count again before SWITCH changes.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the Ahmes GPIO controller: register addresses and width limit.
package io_pkg;

   localparam int IO_MAX_W = 8;

   localparam logic [7:0] IO_ADDR_LED         = 8'h00;
   localparam logic [7:0] IO_ADDR_LED_TOGGLE  = 8'h01;
   localparam logic [7:0] IO_ADDR_SWITCH      = 8'h04;
   localparam logic [7:0] IO_ADDR_EDGE_STATUS = 8'h05;
   localparam logic [7:0] IO_ADDR_EDGE_MASK   = 8'h06;
   localparam logic [7:0] IO_ADDR_EDGE_POL    = 8'h07;

endpackage

// File: rtl/io_debounce.sv
// Single-bit debouncer: the output follows the synchronised input only after it has
// differed from the output for DEB_CYCLES consecutive cycles.
module io_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sync_i,
   output logic stable_o
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;

   // Any cycle where the input agrees with the output restarts the count.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync_i == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         stable_d = sync_i;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped GPIO controller: LEDs with set/toggle, synchronised switches, edge status/irq.
// Optional per-bit debounce is compiled in when IO_DEBOUNCE_EN is defined.
module io_port_ctrl
   import io_pkg::*;
#(
   parameter int IN_W       = 4,
   parameter int OUT_W      = 4,
   parameter int DEB_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       addr,
   input  logic [7:0]       write_data,
   input  logic             write_en,
   input  logic             read_en,
   output logic [7:0]       read_data,
   input  logic [IN_W-1:0]  in_switches,
   output logic [OUT_W-1:0] out_leds,
   output logic             irq
);

   if ((IN_W < 1) || (IN_W > IO_MAX_W) || (OUT_W < 1) || (OUT_W > IO_MAX_W) ||
       (DEB_CYCLES < 1)) begin : gBadParam
      $error("io_port_ctrl: parameter out of range");
   end

   logic [OUT_W-1:0] led_q, led_d;
   logic [IN_W-1:0]  syncMeta_q, sync_q;
   logic [IN_W-1:0]  stable, stablePrev_q;
   logic [IN_W-1:0]  status_q, status_d;
   logic [IN_W-1:0]  mask_q, mask_d;
   logic [IN_W-1:0]  pol_q, pol_d;
   logic [IN_W-1:0]  edgeEvt;

`ifdef IO_DEBOUNCE_EN
   for (genvar i = 0; i < IN_W; i++) begin : gDeb
      io_debounce #(
         .DEB_CYCLES(DEB_CYCLES)
      ) uDeb (
         .clk     (clk),
         .reset_n (reset_n),
         .sync_i  (sync_q[i]),
         .stable_o(stable[i])
      );
   end
`else
   assign stable = sync_q;
`endif

   // Polarity only selects which transition counts, so rewriting pol never fires an event.
   assign edgeEvt = (pol_q & stable & ~stablePrev_q) | (~pol_q & ~stable & stablePrev_q);

   // Register writes; a new edge event is OR'd in after W1C so the set wins a collision.
   always_comb begin
      led_d    = led_q;
      status_d = status_q;
      mask_d   = mask_q;
      pol_d    = pol_q;
      if (write_en) begin
         case (addr)
            IO_ADDR_LED:         led_d    = write_data[OUT_W-1:0];
            IO_ADDR_LED_TOGGLE:  led_d    = led_q ^ write_data[OUT_W-1:0];
            IO_ADDR_EDGE_STATUS: status_d = status_q & ~write_data[IN_W-1:0];
            IO_ADDR_EDGE_MASK:   mask_d   = write_data[IN_W-1:0];
            IO_ADDR_EDGE_POL:    pol_d    = write_data[IN_W-1:0];
            default: ;
         endcase
      end
      status_d = status_d | edgeEvt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         led_q        <= '0;
         syncMeta_q   <= '0;
         sync_q       <= '0;
         stablePrev_q <= '0;
         status_q     <= '0;
         mask_q       <= '0;
         pol_q        <= '1;
      end else begin
         led_q        <= led_d;
         syncMeta_q   <= in_switches;
         sync_q       <= syncMeta_q;
         stablePrev_q <= stable;
         status_q     <= status_d;
         mask_q       <= mask_d;
         pol_q        <= pol_d;
      end
   end

   // Combinational read port, zero-extended; unmapped and write-only addresses read 0.
   always_comb begin
      read_data = 8'h00;
      if (read_en) begin
         case (addr)
            IO_ADDR_LED:         read_data = 8'(led_q);
            IO_ADDR_SWITCH:      read_data = 8'(stable);
            IO_ADDR_EDGE_STATUS: read_data = 8'(status_q);
            IO_ADDR_EDGE_MASK:   read_data = 8'(mask_q);
            IO_ADDR_EDGE_POL:    read_data = 8'(pol_q);
            default:             read_data = 8'h00;
         endcase
      end
   end

   assign out_leds = led_q;
   assign irq      = |(status_q & mask_q);

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl; expected read values go through a scoreboard queue.
// Timing expectations adapt to whether IO_DEBOUNCE_EN is defined (DEB_CYCLES=4).
module tb_io_port_ctrl;

`ifdef IO_DEBOUNCE_EN
   localparam int DEB = 4;
`else
   localparam int DEB = 0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] addr;
   logic [7:0] write_data;
   logic       write_en;
   logic       read_en;
   logic [7:0] read_data;
   logic [3:0] in_switches;
   logic [3:0] out_leds;
   logic       irq;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } sbEntry_t;

   sbEntry_t sbQ[$];
   int       total = 0;
   int       bad   = 0;

   always #5 clk = ~clk;

   io_port_ctrl #(
      .IN_W      (4),
      .OUT_W     (4),
      .DEB_CYCLES(4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .addr       (addr),
      .write_data (write_data),
      .write_en   (write_en),
      .read_en    (read_en),
      .read_data  (read_data),
      .in_switches(in_switches),
      .out_leds   (out_leds),
      .irq        (irq)
   );

   task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%02h want 0x%02h", tag, actual, expected);
      end
   endtask

   // Leaves the bench at the falling edge after n rising edges.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [3:0] sw);
      in_switches = sw;
   endtask

   task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
      addr       = a;
      write_data = d;
      write_en   = 1'b1;
      tick(1);
      write_en   = 1'b0;
   endtask

   task automatic readNow(input string tag, input logic [7:0] exp);
      sbEntry_t e;
      sbQ.push_back('{tag, exp});
      #1;
      e = sbQ.pop_front();
      checkOutput(e.tag, read_data, e.exp);
   endtask

   task automatic readReg(input string tag, input logic [7:0] a, input logic [7:0] exp);
      addr    = a;
      read_en = 1'b1;
      readNow(tag, exp);
      read_en = 1'b0;
   endtask

   initial begin
      reset_n     = 1'b0;
      addr        = 8'h00;
      write_data  = 8'h00;
      write_en    = 1'b0;
      read_en     = 1'b0;
      in_switches = 4'h0;

      tick(2);
      checkOutput("rstLeds", 8'(out_leds), 8'h00);
      checkOutput("rstIrq", {7'b0, irq}, 8'h00);
      readReg("rstPol", 8'h07, 8'h0F);
      readReg("rstStatus", 8'h05, 8'h00);
      reset_n = 1'b1;
      tick(1);

      // LED set, toggle, truncation, unmapped and read-disabled behaviour
      writeReg(8'h00, 8'h0A);
      writeReg(8'h01, 8'h0F);
      checkOutput("ledToggle", 8'(out_leds), 8'h05);
      readReg("ledRead", 8'h00, 8'h05);
      readReg("toggleRead", 8'h01, 8'h00);
      writeReg(8'h00, 8'hFF);
      readReg("ledTrunc", 8'h00, 8'h0F);
      readReg("unmapped", 8'h02, 8'h00);
      addr = 8'h00;
      read_en = 1'b0;
      readNow("noReadEn", 8'h00);
      addr = 8'h00;
      write_data = 8'h03;
      write_en = 1'b1;
      read_en = 1'b1;
      readNow("rdDuringWr", 8'h0F);
      tick(1);
      write_en = 1'b0;
      read_en = 1'b0;
      readReg("rdAfterWr", 8'h00, 8'h03);

      // Switch path latency, edge by edge (mask=0 so irq stays low)
      applyStimulus(4'h9);
      for (int k = 1; k <= 3 + DEB; k++) begin
         tick(1);
         readReg($sformatf("sw_e%0d", k), 8'h04, (k >= 2 + DEB) ? 8'h09 : 8'h00);
         readReg($sformatf("st_e%0d", k), 8'h05, (k >= 3 + DEB) ? 8'h09 : 8'h00);
      end
      checkOutput("irqMasked", {7'b0, irq}, 8'h00);
      writeReg(8'h05, 8'hFF);
      readReg("w1cAll", 8'h05, 8'h00);

      // Short glitch on bit 1: filtered only when debouncing
      applyStimulus(4'hB);
      tick(3);
      applyStimulus(4'h9);
      tick(6 + DEB);
      readReg("glitchSw", 8'h04, 8'h09);
      readReg("glitchSt", 8'h05, (DEB == 0) ? 8'h02 : 8'h00);
      writeReg(8'h05, 8'hFF);

      // Rising edge on bit 0 with mask=1, pol=1 drives irq; W1C drops it
      writeReg(8'h07, 8'h01);
      writeReg(8'h06, 8'h01);
      applyStimulus(4'h8);
      tick(4 + DEB);
      readReg("fallIgnored", 8'h05, 8'h00);
      applyStimulus(4'h9);
      tick(3 + DEB);
      readReg("riseSet", 8'h05, 8'h01);
      checkOutput("irqHigh", {7'b0, irq}, 8'h01);
      writeReg(8'h05, 8'h01);
      checkOutput("irqCleared", {7'b0, irq}, 8'h00);

      // Falling polarity
      writeReg(8'h07, 8'h00);
      tick(2);
      readReg("polNoEvent", 8'h05, 8'h00);
      applyStimulus(4'h8);
      tick(3 + DEB);
      readReg("fallSet", 8'h05, 8'h01);
      writeReg(8'h05, 8'h01);
      applyStimulus(4'h9);
      tick(4 + DEB);
      readReg("riseIgnored", 8'h05, 8'h00);

      // Unmasked bit 1 sets status without irq
      writeReg(8'h07, 8'h0F);
      applyStimulus(4'hB);
      tick(4 + DEB);
      readReg("unmaskedSt", 8'h05, 8'h02);
      checkOutput("unmaskedIrq", {7'b0, irq}, 8'h00);
      writeReg(8'h05, 8'hFF);

      // W1C of bit 2 lands on the same edge as its new event
      applyStimulus(4'hF);
      tick(2 + DEB);
      writeReg(8'h05, 8'h04);
      readReg("collision", 8'h05, 8'h04);
      writeReg(8'h06, 8'h0F);
      checkOutput("irqAllMask", {7'b0, irq}, 8'h01);

      // Reset in the middle of an input transition
      applyStimulus(4'h0);
      tick(4 + DEB);
      writeReg(8'h00, 8'h0F);
      applyStimulus(4'h5);
      tick(1 + DEB);
      readReg("preRstSw", 8'h04, 8'h00);
      reset_n = 1'b0;
      #1;
      checkOutput("rstMidLeds", 8'(out_leds), 8'h00);
      checkOutput("rstMidIrq", {7'b0, irq}, 8'h00);
      readReg("rstMidRead", 8'h00, 8'h00);
      tick(1);
      reset_n = 1'b1;
      tick(1 + DEB);
      readReg("postRstEarly", 8'h04, 8'h00);
      tick(1);
      readReg("postRstSw", 8'h04, 8'h05);
      tick(1);
      readReg("postRstSt", 8'h05, 8'h05);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
